// File: rtl/ps_tx_scheduler_pkg.sv
// ps_tx_scheduler_pkg: shared link-state encoding, ordered-set byte constants and helpers
package ps_tx_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TRAIN = 2'd1, ACTIVE = 2'd2} state_t;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/ps_tx_scheduler_rr_arbiter4.sv
// rr_arbiter4: 4-way one-hot grant, lowest-index-first search starting at ptr
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);
  logic [7:0] dbl, back;
  logic [3:0] rot, pick;
  assign dbl   = {req, req} >> ptr;
  assign rot   = dbl[3:0];
  assign pick  = rot & (~rot + 4'd1);
  assign back  = {pick, pick} << ptr;
  assign grant = back[7:4];
endmodule

// File: rtl/ps_tx_scheduler.sv
// ps_tx_scheduler: link FSM sending COM training, round-robin burst arbitration and periodic SKP insertion
module ps_tx_scheduler
  import ps_tx_scheduler_pkg::*;
#(
  parameter int COM_COUNT    = 4,
  parameter int MAX_BURST    = 8,
  parameter int SKP_INTERVAL = 64
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  ack,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic [1:0]  state_out
);
  state_t      state, state_nx;
  logic [7:0]  train_cnt, burst_cnt;
  logic [15:0] skp_cnt;
  logic [1:0]  last_winner, ptr, win;
  logic [3:0]  grant;
  logic        active, skp_due, others, keep, granted;
  assign active  = state == ACTIVE && enable;
  assign skp_due = skp_cnt == 16'(SKP_INTERVAL - 1);
  assign others  = |(req & ~(4'b0001 << last_winner));
  // owner keeps the bus unless it has used its burst allowance while someone else waits
  assign keep    = burst_cnt != 8'd0 && req[last_winner] && !(burst_cnt == 8'(MAX_BURST) && others);
  assign ptr     = keep ? last_winner : last_winner + 2'd1;
  rr_arbiter4 u_arb (.req(req), .ptr(ptr), .grant(grant));
  assign win       = oh2idx(grant);
  assign ack       = (active && !skp_due) ? grant : 4'b0000;
  assign granted   = |ack;
  assign state_out = state;
  always_comb begin
    state_nx = !enable ? IDLE :
               state == IDLE ? TRAIN :
               (state == TRAIN && train_cnt == 8'(COM_COUNT - 1)) ? ACTIVE : state;
  end
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      train_cnt   <= 8'd0;
      burst_cnt   <= 8'd0;
      skp_cnt     <= 16'd0;
      last_winner <= 2'd3;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
    end else begin
      train_cnt   <= (state == TRAIN && state_nx == TRAIN) ? train_cnt + 8'd1 : 8'd0;
      skp_cnt     <= (!active || skp_due) ? 16'd0 : skp_cnt + 16'd1;
      // a SKP slot freezes the burst count; a cycle with no grant ends the burst
      burst_cnt   <= granted ? (keep ? burst_cnt + 8'(burst_cnt != 8'(MAX_BURST)) : 8'd1) :
                     (active && skp_due) ? burst_cnt : 8'd0;
      last_winner <= granted ? win : last_winner;
      data_out    <= (enable && state == TRAIN) ? COM :
                     (active && skp_due) ? SKP :
                     granted ? data_in[{win, 3'b000} +: 8] : 8'h00;
      valid_out   <= (enable && state == TRAIN) || (active && (skp_due || |req));
    end
  end
endmodule
